// File: rtl/ltl_nfa_pkg.sv
// Shared types for the LTL NFA monitor.
// Config selectors, start sub-selects, report-entry sizing.
package ltl_nfa_pkg;

  typedef enum logic [1:0] {
    CFG_MATCH  = 2'd0,
    CFG_PRED   = 2'd1,
    CFG_START  = 2'd2,
    CFG_REPORT = 2'd3
  } cfg_sel_e;

  localparam logic START_SOD = 1'b0;
  localparam logic START_ALL = 1'b1;

  // Packed width of a report entry {idx, vec}.
  function automatic int rpt_entry_w(
    input int idx_w,
    input int vec_w
  );
    return idx_w + vec_w;
  endfunction

endpackage

// File: rtl/ltl_report_fifo.sv
// Report FIFO for the NFA monitor.
// Drops on full unless popped in the same cycle; sticky overflow.
module ltl_report_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop_ready,
  output logic         valid,
  output logic [W-1:0] head,
  output logic         overflow
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          full;
  logic          pop_en;
  logic          push_en;

  assign full    = count == (PW+1)'(DEPTH);
  assign valid   = count != '0;
  assign pop_en  = pop_ready & valid;
  assign push_en = push & (~full | pop_en);
  assign head    = mem[rd_ptr];

  // Pointers, occupancy and the sticky drop flag.
  always_ff @(posedge clk) begin
    if (reset | flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push & ~push_en) overflow <= 1'b1;
    end
  end

  // Entry storage; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ltl_nfa_monitor.sv
// Programmable homogeneous NFA monitor over a symbol stream.
// STE vector, config tables and timestamped report queue.
module ltl_nfa_monitor
  import ltl_nfa_pkg::*;
#(
  parameter int NUM_STE   = 16,
  parameter int SYM_W     = 8,
  parameter int IDX_W     = 16,
  parameter int RPT_DEPTH = 4,
  localparam int SW       = $clog2(NUM_STE),
  localparam int AW       = (SYM_W > SW) ? SYM_W : SW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               flush,
  input  logic [SYM_W-1:0]   symbols,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_sel,
  input  logic [AW-1:0]      cfg_addr,
  input  logic [NUM_STE-1:0] cfg_wdata,
  output logic [NUM_STE-1:0] active_state,
  output logic [IDX_W-1:0]   sym_count,
  output logic               rpt_valid,
  input  logic               rpt_ready,
  output logic [IDX_W-1:0]   rpt_idx,
  output logic [NUM_STE-1:0] rpt_vec,
  output logic               rpt_overflow
);

  localparam int NSYM = 2**SYM_W;
  localparam int EW   = rpt_entry_w(IDX_W, NUM_STE);

  typedef struct packed {
    logic [IDX_W-1:0]   idx;
    logic [NUM_STE-1:0] vec;
  } rpt_t;

  logic [NUM_STE-1:0] match_tab [NSYM];
  logic [NUM_STE-1:0] pred [NUM_STE];
  logic [NUM_STE-1:0] sod_mask;
  logic [NUM_STE-1:0] all_mask;
  logic [NUM_STE-1:0] rpt_mask;
  logic               sod;

  logic               cfg_ok;
  logic [NUM_STE-1:0] enable;
  logic [NUM_STE-1:0] sym_match;
  logic [NUM_STE-1:0] active_next;
  logic [NUM_STE-1:0] rpt_hit;
  logic               push;
  rpt_t               push_e;
  rpt_t               head_e;

  assign cfg_ok = cfg_we & ~run;

  // Configuration tables; locked while symbols are consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NSYM; s++) match_tab[s] <= '0;
      for (int j = 0; j < NUM_STE; j++) pred[j] <= '0;
      sod_mask <= '0;
      all_mask <= '0;
      rpt_mask <= '0;
    end else if (cfg_ok) begin
      unique case (cfg_sel_e'(cfg_sel))
        CFG_MATCH:
          match_tab[cfg_addr[SYM_W-1:0]] <= cfg_wdata;
        CFG_PRED:
          if (int'(cfg_addr) < NUM_STE)
            pred[cfg_addr[SW-1:0]] <= cfg_wdata;
        CFG_START:
          if (cfg_addr[0] == START_ALL) all_mask <= cfg_wdata;
          else                          sod_mask <= cfg_wdata;
        CFG_REPORT:
          rpt_mask <= cfg_wdata;
      endcase
    end
  end

  // Per-STE enable from predecessors and start types.
  for (genvar j = 0; j < NUM_STE; j++) begin : g_ste
    assign enable[j] = (|(active_state & pred[j]))
                     | all_mask[j]
                     | (sod & sod_mask[j]);
  end

  assign sym_match   = match_tab[symbols];
  assign active_next = enable & sym_match;
  assign rpt_hit     = active_next & rpt_mask;
  assign push        = run & ~flush & (|rpt_hit);
  assign push_e      = '{idx: sym_count, vec: rpt_hit};

  // Stream state: activity, symbol index, start-of-data arm.
  always_ff @(posedge clk) begin
    if (reset | flush) begin
      active_state <= '0;
      sym_count    <= '0;
      sod          <= 1'b1;
    end else if (run) begin
      active_state <= active_next;
      sym_count    <= sym_count + 1'b1;
      sod          <= 1'b0;
    end
  end

  ltl_report_fifo #(
    .DEPTH (RPT_DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .push_data (push_e),
    .pop_ready (rpt_ready),
    .valid     (rpt_valid),
    .head      (head_e),
    .overflow  (rpt_overflow)
  );

  assign rpt_idx = head_e.idx;
  assign rpt_vec = head_e.vec;

endmodule
